// File: rtl/float_log2.sv
// float_log2: fixed-point log2 of an IEEE-754 single-precision operand.
// Result is Q9.23: the integer part comes straight from the unbiased exponent.
// The 23 fraction bits come from repeated squaring of the significand,
// one bit per cycle, MSB first. Values are truncated, so the result never
// exceeds the true log2.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand; in_ready=1
// CALC  | squaring loop; one fraction bit per cycle, 23 cycles
// DONE  | result presented; out_valid=1 until out_ready
module float_log2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] flt_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] log_value,
  output logic        log_err,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_VALUE = 32'h8000_0000;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] log_value_q;
  logic        log_err_q;
  logic [8:0]  int_q;
  logic [23:0] y_q;
  logic [21:0] frac_q;
  logic [4:0]  cnt_q;

  logic        sign_w;
  logic [7:0]  exp_w;
  logic [22:0] mant_w;
  logic        special_w;
  logic [24:0] prod_hi_w;
  logic        bit_w;
  logic [23:0] y_d;

  assign sign_w    = flt_value[31];
  assign exp_w     = flt_value[30:23];
  assign mant_w    = flt_value[22:0];
  assign special_w = sign_w || (exp_w == 8'd0) || (exp_w == 8'd255);

  // Keep only p[47:23] of y*y; the lower product bits are always discarded.
  assign prod_hi_w = 25'(({24'd0, y_q} * {24'd0, y_q}) >> 23);
  assign bit_w     = prod_hi_w[24];
  assign y_d       = bit_w ? prod_hi_w[24:1] : prod_hi_w[23:0];

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      log_value_q <= 32'h0000_0000;
      log_err_q   <= 1'b0;
      int_q       <= 9'd0;
      y_q         <= 24'd0;
      frac_q      <= 22'd0;
      cnt_q       <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (special_w) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              log_value_q <= ERR_VALUE;
              log_err_q   <= 1'b1;
            end else begin
              state_q <= CALC;
              int_q   <= {1'b0, exp_w} - 9'd127;
              y_q     <= {1'b1, mant_w};
              frac_q  <= 22'd0;
              cnt_q   <= 5'd0;
            end
          end
        end
        CALC: begin
          y_q    <= y_d;
          frac_q <= {frac_q[20:0], bit_w};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd22) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            log_value_q <= {int_q, frac_q, bit_w};
            log_err_q   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign log_value = log_value_q;
  assign log_err   = log_err_q;

endmodule
